// File: rtl/dmux_router_0_if.sv
// dmux_router_0_if
// Bundles the producer-side valid/ready stream, the per-destination output
// slots and the accepted-word counter of the fan-out router.
//   in_valid/in_ready/in_data/in_sel : single input stream with select field
//   out_valid/out_ready/out_data     : N_OUT destination handshakes, slot i
//                                      at out_data[i*WIDTH +: WIDTH]
//   accept_cnt                       : words accepted since reset
// Modports: slave = router side, master = producer/consumer (environment).
interface dmux_router_0_if #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 2,
   parameter int CNT_W = 16
);
   localparam int N_OUT = 1 << SEL_W;

   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic [SEL_W-1:0]       in_sel;
   logic [N_OUT-1:0]       out_valid;
   logic [N_OUT-1:0]       out_ready;
   logic [N_OUT*WIDTH-1:0] out_data;
   logic [CNT_W-1:0]       accept_cnt;

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, accept_cnt
   );

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, accept_cnt
   );
endinterface

// File: rtl/dmux_router_0.sv
// dmux_router_0
// Routing fan-out stage: one valid/ready input stream is steered to one of
// N_OUT = 2**SEL_W destinations chosen by in_sel. Each destination owns a
// one-entry holding slot, so a stalled consumer only blocks words addressed
// to it. Back-to-back pop and refill of a slot gives one word/cycle/slot.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears slots, valids and counter
//   bus   : dmux_router_0_if.slave (stream in, slots out, accept_cnt)
module dmux_router_0 #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 2,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   dmux_router_0_if.slave        bus
);
   localparam int N_OUT = 1 << SEL_W;

   logic [N_OUT-1:0]            vld_q, vld_d;
   logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        ready_o;
   logic                        accept;

   // Readiness looks only at the addressed slot: it can take a word if it is
   // empty or is being drained this same cycle.
   assign ready_o = ~vld_q[bus.in_sel] | bus.out_ready[bus.in_sel];
   assign accept  = bus.in_valid & ready_o;

   always_comb begin
      // Pops clear their slot; an accept into the same slot re-sets it below,
      // which is what lets a slot refill in the cycle it drains.
      vld_d  = vld_q & ~bus.out_ready;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (accept) begin
         vld_d[bus.in_sel]  = 1'b1;
         data_d[bus.in_sel] = bus.in_data;
         cnt_d              = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q  <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.in_ready   = ready_o;
   assign bus.out_valid  = vld_q;
   assign bus.out_data   = data_q;
   assign bus.accept_cnt = cnt_q;
endmodule
